// File: rtl/spsram_ext_arbiter.sv
// Round-robin arbiter/sequencer putting two requesters onto one single-port SRAM.
// Latency: grant and SRAM issue 1 cycle after a request is seen in IDLE; read data returns 2+RD_LAT cycles after the request.
// Backpressure: requests are sampled only in IDLE; a requester holds its command until its o_gnt pulse.
// Ports: i_req*/i_we*/i_addr*/i_wdata* command inputs; o_gnt* grant pulses; o_rvalid*/o_rdata* read returns;
//        o_busy = not idle; o_mem_* drive the SRAM port (all active-high); i_mem_data is SRAM read data.
module spsram_ext_arbiter #(
  parameter int BW_DATA = 64,
  parameter int BW_ADDR = 6,
  parameter int RD_LAT  = 1
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_req0,
  input  logic               i_req1,
  input  logic               i_we0,
  input  logic               i_we1,
  input  logic [BW_ADDR-1:0] i_addr0,
  input  logic [BW_ADDR-1:0] i_addr1,
  input  logic [BW_DATA-1:0] i_wdata0,
  input  logic [BW_DATA-1:0] i_wdata1,
  output logic               o_gnt0,
  output logic               o_gnt1,
  output logic               o_rvalid0,
  output logic               o_rvalid1,
  output logic [BW_DATA-1:0] o_rdata0,
  output logic [BW_DATA-1:0] o_rdata1,
  output logic               o_busy,
  output logic               o_mem_cen,
  output logic               o_mem_wen,
  output logic               o_mem_oen,
  output logic [BW_ADDR-1:0] o_mem_addr,
  output logic [BW_DATA-1:0] o_mem_data,
  input  logic [BW_DATA-1:0] i_mem_data
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic               ptr, ptr_nxt;        // port holding priority when both request
  logic               owner, owner_nxt;    // port that owns the command in flight
  logic               win;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               gnt0_nxt, gnt1_nxt, rvalid0_nxt, rvalid1_nxt, busy_nxt;
  logic               cen_nxt, wen_nxt, oen_nxt;
  logic [BW_ADDR-1:0] addr_nxt;
  logic [BW_DATA-1:0] data_nxt, rdata0_nxt, rdata1_nxt;

  // Every output is a flop; this process computes the value each one takes
  // at the next edge alongside the next state.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    owner_nxt   = owner;
    cnt_nxt     = cnt;
    win         = 1'b0;
    gnt0_nxt    = 1'b0;
    gnt1_nxt    = 1'b0;
    rvalid0_nxt = 1'b0;
    rvalid1_nxt = 1'b0;
    cen_nxt     = 1'b0;
    wen_nxt     = 1'b0;
    oen_nxt     = 1'b0;
    addr_nxt    = o_mem_addr;
    data_nxt    = o_mem_data;
    rdata0_nxt  = o_rdata0;
    rdata1_nxt  = o_rdata1;
    case (state)
      IDLE: begin
        if (i_req0 || i_req1) begin
          // win = 1 selects port 1
          win       = (i_req0 && i_req1) ? ptr : i_req1;
          owner_nxt = win;
          ptr_nxt   = ~win;
          gnt0_nxt  = ~win;
          gnt1_nxt  = win;
          cen_nxt   = 1'b1;
          wen_nxt   = win ? i_we1 : i_we0;
          oen_nxt   = ~wen_nxt;
          addr_nxt  = win ? i_addr1 : i_addr0;
          data_nxt  = win ? i_wdata1 : i_wdata0;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (o_mem_wen) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = CNT_W'(RD_LAT);
          oen_nxt   = 1'b1;
          state_nxt = RWAIT;
        end
      end
      RWAIT: begin
        oen_nxt = 1'b1;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          // Last wait cycle: SRAM data is valid now, capture it for the owner.
          oen_nxt   = 1'b0;
          state_nxt = RESP;
          if (owner) begin
            rdata1_nxt  = i_mem_data;
            rvalid1_nxt = 1'b1;
          end else begin
            rdata0_nxt  = i_mem_data;
            rvalid0_nxt = 1'b1;
          end
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      owner      <= 1'b0;
      cnt        <= '0;
      o_gnt0     <= 1'b0;
      o_gnt1     <= 1'b0;
      o_rvalid0  <= 1'b0;
      o_rvalid1  <= 1'b0;
      o_rdata0   <= '0;
      o_rdata1   <= '0;
      o_busy     <= 1'b0;
      o_mem_cen  <= 1'b0;
      o_mem_wen  <= 1'b0;
      o_mem_oen  <= 1'b0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      owner      <= owner_nxt;
      cnt        <= cnt_nxt;
      o_gnt0     <= gnt0_nxt;
      o_gnt1     <= gnt1_nxt;
      o_rvalid0  <= rvalid0_nxt;
      o_rvalid1  <= rvalid1_nxt;
      o_rdata0   <= rdata0_nxt;
      o_rdata1   <= rdata1_nxt;
      o_busy     <= busy_nxt;
      o_mem_cen  <= cen_nxt;
      o_mem_wen  <= wen_nxt;
      o_mem_oen  <= oen_nxt;
      o_mem_addr <= addr_nxt;
      o_mem_data <= data_nxt;
    end
  end

endmodule

// File: tb/tb_spsram_ext_arbiter.sv
// Bench for spsram_ext_arbiter: main instance (RD_LAT=1) against a transaction-level model
// plus an emulated SRAM; two extra instances (RD_LAT=2,4) for the read-latency sweep.
// Inputs are driven 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_spsram_ext_arbiter;
  localparam int LAT = 1;

  logic        clk, rstn;
  logic        req0, req1, we0, we1;
  logic [5:0]  addr0, addr1;
  logic [63:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy, mem_cen, mem_wen, mem_oen;
  logic [5:0]  mem_addr;
  logic [63:0] mem_wdat, rdata0, rdata1, mem_rdat;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  spsram_ext_arbiter #(.BW_DATA(64), .BW_ADDR(6), .RD_LAT(LAT)) u_dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
    .o_rdata0(rdata0), .o_rdata1(rdata1), .o_busy(busy),
    .o_mem_cen(mem_cen), .o_mem_wen(mem_wen), .o_mem_oen(mem_oen),
    .o_mem_addr(mem_addr), .o_mem_data(mem_wdat), .i_mem_data(mem_rdat)
  );

  // Latency-sweep instances: port 0 reads only; SRAM data is a per-cycle stamp.
  logic [1:0]       sw_req;
  logic [1:0][5:0]  sw_addr;
  logic [31:0]      memcnt = 0;
  wire  [1:0]       sw_gnt0, sw_gnt1, sw_rv0, sw_rv1, sw_busy, sw_cen, sw_wen, sw_oen;
  wire  [1:0][5:0]  sw_maddr;
  wire  [1:0][63:0] sw_mdat, sw_rd0, sw_rd1, sw_min;

  for (genvar g = 0; g < 2; g++) begin : g_sw
    localparam int L = (g == 0) ? 2 : 4;
    assign sw_min[g] = {32'hA5A5_0000, memcnt};
    spsram_ext_arbiter #(.BW_DATA(64), .BW_ADDR(6), .RD_LAT(L)) u_sw (
      .i_clk(clk), .i_rstn(rstn),
      .i_req0(sw_req[g]), .i_req1(1'b0), .i_we0(1'b0), .i_we1(1'b0),
      .i_addr0(sw_addr[g]), .i_addr1(6'd0), .i_wdata0(64'd0), .i_wdata1(64'd0),
      .o_gnt0(sw_gnt0[g]), .o_gnt1(sw_gnt1[g]), .o_rvalid0(sw_rv0[g]), .o_rvalid1(sw_rv1[g]),
      .o_rdata0(sw_rd0[g]), .o_rdata1(sw_rd1[g]), .o_busy(sw_busy[g]),
      .o_mem_cen(sw_cen[g]), .o_mem_wen(sw_wen[g]), .o_mem_oen(sw_oen[g]),
      .o_mem_addr(sw_maddr[g]), .o_mem_data(sw_mdat[g]), .i_mem_data(sw_min[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    memcnt = 32'(cyc);
  end

  // Emulated SRAM: data for a read issued in cycle t is presented during cycle t+LAT;
  // at any other time the read bus carries a junk stamp.
  logic [63:0] sram [64];
  logic [63:0] rpipe [4];
  always @(posedge clk) begin
    if (mem_cen && mem_wen) sram[mem_addr] <= mem_wdat;
    rpipe[0] <= (mem_cen && !mem_wen) ? sram[mem_addr] : {32'hBADC_0DE0, 32'(cyc)};
    for (int i = 1; i < 4; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdat = rpipe[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Transaction-level model: one command record, its grant cycle, and the cycle the
  // arbiter is free again; expected outputs follow from the cycle offset.
  logic        m_tv = 1'b0, m_twe = 1'b0, m_tp = 1'b0, m_ptr = 1'b0;
  int          m_t0 = 0, m_free = 0;
  logic [5:0]  m_taddr = '0;
  logic [63:0] m_tdata = '0, m_texp = '0;
  logic [63:0] m_mem [64];
  logic [63:0] m_rd [2];
  int          glog_p[$], glog_c[$];

  initial begin : monitor
    int rel;
    logic w, e_cen, e_wen, e_oen, e_rv;
    logic [7:0] e_ctrl, a_ctrl;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        m_tv = 1'b0; m_ptr = 1'b0; m_free = 0; m_rd[0] = '0; m_rd[1] = '0;
      end
      rel = cyc - m_t0;
      if (m_tv && !m_twe && rel == LAT + 1) m_rd[m_tp] = m_texp;
      e_cen  = m_tv && rel == 0;
      e_wen  = e_cen && m_twe;
      e_oen  = m_tv && !m_twe && rel >= 0 && rel <= LAT;
      e_rv   = m_tv && !m_twe && rel == LAT + 1;
      e_ctrl = {e_cen && !m_tp, e_cen && m_tp, e_rv && !m_tp, e_rv && m_tp,
                m_tv && rel >= 0 && rel <= (m_twe ? 0 : LAT + 1), e_cen, e_wen, e_oen};
      a_ctrl = {gnt0, gnt1, rvalid0, rvalid1, busy, mem_cen, mem_wen, mem_oen};
      check("ctrl{gnt0,gnt1,rv0,rv1,busy,cen,wen,oen}", 64'(a_ctrl), 64'(e_ctrl));
      if (e_cen || e_oen) check("mem_addr", 64'(mem_addr), 64'(m_taddr));
      if (e_wen) check("mem_data", mem_wdat, m_tdata);
      check("rdata0", rdata0, m_rd[0]);
      check("rdata1", rdata1, m_rd[1]);
      if (gnt0 || gnt1) begin
        glog_p.push_back(gnt1 ? 1 : 0);
        glog_c.push_back(cyc);
      end
      if (rstn && cyc >= m_free && (req0 || req1)) begin
        w       = (req0 && req1) ? m_ptr : req1;
        m_tv    = 1'b1;
        m_tp    = w;
        m_twe   = w ? we1 : we0;
        m_taddr = w ? addr1 : addr0;
        m_tdata = w ? wdata1 : wdata0;
        m_t0    = cyc + 1;
        m_free  = m_twe ? cyc + 2 : cyc + 3 + LAT;
        m_ptr   = ~w;
        if (m_twe) m_mem[m_taddr] = m_tdata;
        else       m_texp = m_mem[m_taddr];
      end
    end
  end

  task automatic drive(input int p, input logic r, input logic w, input logic [5:0] a, input logic [63:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  // Raise a command, hold it until granted, drop it in the cycle after the grant.
  task automatic issue(input int p, input logic w, input logic [5:0] a, input logic [63:0] d,
                       output int t_req, output int t_gnt, output logic [1:0] cw);
    drive(p, 1'b1, w, a, d);
    t_req = cyc;
    t_gnt = -1;
    cw    = 2'b00;
    for (int i = 0; i < 40 && t_gnt < 0; i++) begin
      @(posedge clk); #1;
      if ((p == 0 && gnt0) || (p == 1 && gnt1)) begin
        t_gnt = cyc;
        cw    = {mem_cen, mem_wen};
      end
    end
    check($sformatf("grant_seen_p%0d", p), 64'(t_gnt >= 0), 64'd1);
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, 6'd0, 64'd0);
  endtask

  task automatic wait_rvalid(input int p, output int t);
    t = -1;
    for (int i = 0; i < 40 && t < 0; i++) begin
      @(posedge clk); #1;
      if ((p == 0 && rvalid0) || (p == 1 && rvalid1)) t = cyc;
    end
    check($sformatf("rvalid_seen_p%0d", p), 64'(t >= 0), 64'd1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rstn = 1'b1;
  endtask

  task automatic sweep(input int g, input int lat);
    int tr, tg, trv, noen, nrv;
    logic [63:0] rd;
    tg = -1; trv = -1; noen = 0; nrv = 0; rd = '0;
    sw_req[g]  = 1'b1;
    sw_addr[g] = 6'h11;
    tr = cyc;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (tg >= 0 && cyc == tg + 1) sw_req[g] = 1'b0;
      if (sw_gnt0[g] && tg < 0) tg = cyc;
      if (sw_oen[g]) noen++;
      if (sw_rv0[g]) begin
        nrv++;
        if (trv < 0) begin trv = cyc; rd = sw_rd0[g]; end
      end
    end
    sw_req[g] = 1'b0;
    check($sformatf("sweep%0d_gnt_latency", lat), 64'(tg - tr), 64'd1);
    check($sformatf("sweep%0d_rvalid_latency", lat), 64'(trv - tr), 64'(2 + lat));
    check($sformatf("sweep%0d_oen_cycles", lat), 64'(noen), 64'(lat + 1));
    check($sformatf("sweep%0d_rvalid_count", lat), 64'(nrv), 64'd1);
    check($sformatf("sweep%0d_rdata", lat), rd, {32'hA5A5_0000, 32'(tr + 1 + lat)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int tr, tg, tv, tg0, n_a, n_b;
    logic [1:0] cw;
    logic [5:0]  baddr [5];
    logic [63:0] bpat  [5];
    int          rd_order [5];
    baddr = '{6'd0, 6'd16, 6'd32, 6'd48, 6'd63};
    bpat  = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'hA5A5_5A5A_0F0F_F0F0,
              64'h1357_9BDF_2468_ACE0, 64'hFFFF_0000_FFFF_0000};
    rd_order = '{1, 2, 3, 4, 0};
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    sw_req  = '0;
    sw_addr = '0;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("reset_ctrl", 64'({gnt0, gnt1, rvalid0, rvalid1, busy, mem_cen, mem_wen, mem_oen}), 64'd0);
    check("reset_rdata0", rdata0, 64'd0);
    check("reset_mem_addr_data", {mem_wdat[57:0], mem_addr}, 64'd0);
    rstn = 1'b1;

    // Single write then read on port 0.
    issue(0, 1'b1, 6'h2A, 64'hDEADBEEF_01234567, tr, tg, cw);
    check("wr_gnt_latency", 64'(tg - tr), 64'd1);
    check("wr_cen_wen_at_gnt", 64'(cw), 64'd3);
    issue(0, 1'b0, 6'h2A, 64'd0, tr, tg, cw);
    wait_rvalid(0, tv);
    check("rd_rvalid_latency", 64'(tv - tr), 64'd3);
    check("rd_rdata0", rdata0, 64'hDEADBEEF_01234567);

    // Both ports requesting continuously: grants alternate from port 0, 2 cycles apart.
    do_reset();
    glog_p.delete(); glog_c.delete();
    fork
      begin
        issue(0, 1'b1, 6'h01, 64'h1111_0000_0000_0001, tr, tg, cw);
        issue(0, 1'b1, 6'h01, 64'h1111_0000_0000_0002, tr, tg, cw);
      end
      begin
        int tr1, tg1;
        logic [1:0] cw1;
        issue(1, 1'b1, 6'h02, 64'h2222_0000_0000_0001, tr1, tg1, cw1);
        issue(1, 1'b1, 6'h02, 64'h2222_0000_0000_0002, tr1, tg1, cw1);
      end
    join
    check("alt_grant_count", 64'(glog_p.size()), 64'd4);
    if (glog_p.size() >= 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("alt_grant_port_%0d", i), 64'(glog_p[i]), 64'(i % 2));
      for (int i = 0; i < 3; i++) check($sformatf("alt_grant_gap_%0d", i), 64'(glog_c[i+1] - glog_c[i]), 64'd2);
    end

    // Bank coverage: port 1 writes, port 0 reads back (63 then 0 back to back).
    for (int i = 0; i < 5; i++) issue(1, 1'b1, baddr[i], bpat[i], tr, tg, cw);
    for (int k = 0; k < 5; k++) begin
      issue(0, 1'b0, baddr[rd_order[k]], 64'd0, tr, tg, cw);
      wait_rvalid(0, tv);
      check($sformatf("bank_rdata0_addr%0d", baddr[rd_order[k]]), rdata0, bpat[rd_order[k]]);
      check("bank_rdata1_unchanged", rdata1, 64'd0);
    end

    // Port 1 raises during port 0's RWAIT and is granted after RESP + IDLE.
    issue(0, 1'b0, 6'd63, 64'd0, tr, tg0, cw);
    issue(1, 1'b1, 6'h05, 64'h5555_AAAA_5555_AAAA, tr, tg, cw);
    check("late_req_gnt_offset", 64'(tg - tg0), 64'd4);
    check("late_rdata0", rdata0, 64'hFFFF_0000_FFFF_0000);

    // Port 0 request raised during ISSUE and dropped before IDLE is never served.
    drive(1, 1'b1, 1'b0, 6'h05, 64'd0);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 6'h3F, 64'hBAD0_BAD0_BAD0_BAD0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    n_a = 0; n_b = 0;
    for (int i = 0; i < 8; i++) begin
      n_a += int'(gnt0);
      n_b += int'(mem_cen);
      @(posedge clk); #1;
    end
    check("withdrawn_gnt0_count", 64'(n_a), 64'd0);
    check("withdrawn_cen_count", 64'(n_b), 64'd0);
    check("withdrawn_rdata1", rdata1, 64'h5555_AAAA_5555_AAAA);

    // Reset during RWAIT of a port 0 read: outputs drop, no rvalid, priority back to port 0.
    issue(0, 1'b0, 6'd16, 64'd0, tr, tg, cw);
    rstn = 1'b0;
    #1;
    check("midrst_ctrl", 64'({gnt0, gnt1, rvalid0, rvalid1, busy, mem_cen, mem_wen, mem_oen}), 64'd0);
    check("midrst_rdata0", rdata0, 64'd0);
    check("midrst_rdata1", rdata1, 64'd0);
    repeat (2) begin @(posedge clk); #1; end
    rstn = 1'b1;
    n_a = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_a += int'(rvalid0) + int'(rvalid1);
    end
    check("midrst_no_rvalid", 64'(n_a), 64'd0);
    glog_p.delete(); glog_c.delete();
    fork
      begin
        int ta, tb; logic [1:0] ca;
        issue(0, 1'b1, 6'h20, 64'hC0C0_C0C0_C0C0_C0C0, ta, tb, ca);
      end
      begin
        int tc, td; logic [1:0] cb;
        issue(1, 1'b1, 6'h21, 64'hC1C1_C1C1_C1C1_C1C1, tc, td, cb);
      end
    join
    check("midrst_grant_count", 64'(glog_p.size()), 64'd2);
    if (glog_p.size() >= 2) begin
      check("midrst_first_port", 64'(glog_p[0]), 64'd0);
      check("midrst_second_port", 64'(glog_p[1]), 64'd1);
    end

    // Read-latency sweep on the RD_LAT=2 and RD_LAT=4 instances.
    sweep(0, 2);
    sweep(1, 4);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spsram_ext_arbiter.md
Name: spsram_ext_arbiter

Overview:
- Two-port round-robin arbiter and sequencer for the 64-bit x 64-entry extended single-port SRAM (4 banks x 2 lanes x 32 bit, 6-bit address).
- Two independent requesters (e.g. DMA and CPU side) each issue single read/write commands through a request/grant handshake.
- The block serialises the commands onto the one SRAM port, drives cen/wen/oen with correct timing, and returns read data with a valid pulse to the owning requester.

Parameters:
- BW_DATA, 64, data width of SRAM and requester ports
- BW_ADDR, 6, address width
- RD_LAT, 1, SRAM read latency in cycles from the issue cycle to valid i_mem_data; legal range 1..4

Ports:
- i_clk  input  1  clock
- i_rstn  input  1  asynchronous active-low reset
- i_req0 / i_req1  input  1  command request, port 0 / port 1
- i_we0 / i_we1  input  1  1 = write, 0 = read
- i_addr0 / i_addr1  input  BW_ADDR  command address
- i_wdata0 / i_wdata1  input  BW_DATA  write data
- o_gnt0 / o_gnt1  output  1  one-cycle grant pulse; command accepted
- o_rvalid0 / o_rvalid1  output  1  one-cycle read-data-valid pulse
- o_rdata0 / o_rdata1  output  BW_DATA  read data; held until next capture
- o_busy  output  1  state != IDLE
- o_mem_cen  output  1  SRAM chip enable, active-high
- o_mem_wen  output  1  SRAM write enable, active-high
- o_mem_oen  output  1  SRAM output enable, active-high
- o_mem_addr  output  BW_ADDR  SRAM address
- o_mem_data  output  BW_DATA  SRAM write data
- i_mem_data  input  BW_DATA  SRAM read data

Behaviour:
- Clock and reset: single clock i_clk; asynchronous active-low reset i_rstn.
- Reset values:
  - all outputs 0; state IDLE; priority pointer = port 0; latency counter 0; o_rdata0/1 = 0.
  - Reset mid-operation aborts the command: no o_rvalid is issued and SRAM enables drop to 0 immediately.
- All outputs are registered.
- FSM states: IDLE, ISSUE, RWAIT, RESP.
- IDLE:
  - Requests are sampled only in IDLE.
  - Neither request set: stay in IDLE.
  - One request set: that port wins.
  - Both set: the port named by the pointer wins.
  - Next state is ISSUE. The winner's we/addr/wdata are latched into o_mem_wen/o_mem_addr/o_mem_data. The winner's o_gnt pulses high for exactly the ISSUE cycle.
  - Pointer update on grant: pointer := other port, so the last-granted port gets lowest priority. No starvation: with both ports requesting continuously, grants alternate.
- ISSUE (1 cycle):
  - o_mem_cen = 1.
  - Write: o_mem_wen = 1, o_mem_oen = 0; next state IDLE.
  - Read: o_mem_wen = 0, o_mem_oen = 1; counter loads RD_LAT; next state RWAIT.
- RWAIT:
  - o_mem_cen = 0, o_mem_oen = 1, o_mem_addr held.
  - Counter decrements each cycle.
  - In the cycle the counter reaches 1, i_mem_data is captured into the owning port's o_rdata at the clock edge; next state RESP.
  - RWAIT lasts exactly RD_LAT cycles.
- RESP (1 cycle):
  - The owner's o_rvalid = 1; o_mem_oen = 0; next state IDLE.
  - The non-owner's o_rdata is unchanged.
- Latency from request seen in IDLE:
  - Write: grant and SRAM write in cycle +1; next arbitration in cycle +2.
  - Read: grant in cycle +1, o_rvalid in cycle +2+RD_LAT; next arbitration in cycle +3+RD_LAT.
- Requester rules:
  - Hold req/we/addr/wdata stable until o_gnt; drop or change them in the cycle after o_gnt.
  - A request withdrawn before grant is legal and simply ignored.
  - Requests raised while o_busy = 1 wait; they are not lost while held.
- Write data/address values are not checked; all 64 addresses are legal, including wrap from 63 to 0 across back-to-back commands.
- o_mem_cen and o_gnt0/o_gnt1 are never high in the same cycle for different ports. o_gnt0 and o_gnt1 are mutually exclusive.

Test Plan:
- Reset/idle: assert i_rstn=0 mid-read (during RWAIT) -> all outputs 0 immediately; after release no o_rvalid; the next request is served starting from port 0 priority.
- Single write then read, port 0, RD_LAT=1:
  - write addr 6'h2A data 64'hDEADBEEF_01234567 -> o_gnt0 and o_mem_cen=1, o_mem_wen=1 in cycle +1.
  - read addr 6'h2A -> o_rvalid0 in cycle +3 with o_rdata0 = 64'hDEADBEEF_01234567.
- Simultaneous requests: after reset, both ports request writes continuously with different data -> grants in order port0, port1, port0, port1, each separated by 2 cycles; o_gnt0 and o_gnt1 never both high.
- Bank coverage: write distinct patterns to addresses 0, 16, 32, 48 and 63 via port 1, then read each via port 0 -> each o_rdata0 matches its pattern; o_rdata1 unchanged throughout.
- Read latency sweep: RD_LAT = 1, 2, 4 -> o_rvalid occurs exactly 2+RD_LAT cycles after the request is seen in IDLE; o_mem_oen stays high for RD_LAT+1 cycles.
- Withdrawn/late request: port 1 raises req while port 0's read is in RWAIT and holds it -> granted in the cycle after RESP+IDLE. A port 0 request dropped before grant -> never granted, no SRAM access.
